output_buffer_stream: RTL and testbench
=======================================

Name: output_buffer_stream

Overview:
- Parametrised successor output buffer between the eFlash PIM macro and the RISC-V load path.
- Captures a flat N_GROUPS x GROUP_W result word, in one of two modes:
  - raw (read) mode: stores the word as-is.
  - MAC mode: bit-serially shift-accumulates IN_BITS consecutive results per group, then applies an optional zero-point subtraction.
- Drains the groups to the core over a valid/ready stream, either with an auto-incrementing index or starting from a random index, with a last-beat flag.
- Adds saturation, sticky overflow and an explicit FSM.

Parameters:
- N_GROUPS, 32, number of mapping groups (output words).
- GROUP_W, 32, bits per group slice of output_i (signed in MAC mode).
- ACC_W, 32, accumulator/output width; ACC_W >= GROUP_W.
- IN_BITS, 8, input bit-planes per MAC operation.
- IDX_W, $clog2(N_GROUPS), group index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- output_i  in  N_GROUPS*GROUP_W  eFlash result; group g = output_i[N_GROUPS*GROUP_W-1-GROUP_W*g -: GROUP_W]
- mode_i  in  1  0 = raw, 1 = MAC; sampled on start_i
- start_i  in  1  begin a new operation (clears buffer)
- cap_en_i  in  1  output_i valid this cycle; capture/accumulate one plane
- zp_en_i  in  1  subtract zero point at finalise; sampled on start_i
- zero_point_i  in  ACC_W  signed zero point; sampled on start_i
- drain_i  in  1  begin drain
- drain_idx_i  in  IDX_W  first group to send; sampled on drain_i
- out_data_o  out  ACC_W  group data
- out_valid_o  out  1  data valid
- out_last_o  out  1  beat carries group N_GROUPS-1
- out_ready_i  in  1  consumer accepts
- busy_o  out  1  FSM not IDLE/READY
- ready_o  out  1  results available (READY state)
- ovf_o  out  1  sticky saturation flag, cleared on start_i
- err_o  out  1  sticky protocol error, cleared on start_i

Behaviour:
- Reset: FSM = IDLE. All buffer entries 0, plane counter 0, drain index 0. All outputs 0.
- FSM states: IDLE, CAPTURE, FINAL, READY, DRAIN.
  - IDLE/READY/DRAIN --start_i--> CAPTURE, next cycle. start_i aborts any operation: buffer cleared, plane counter 0, ovf_o/err_o cleared.
  - CAPTURE, raw mode, cap_en_i: buf[g] <= zero-extend(group g). Next state READY; zero point is not applied.
  - CAPTURE, MAC mode, cap_en_i: buf[g] <= sat(buf[g] + (sext(group g) << plane)); plane++.
    - When plane == IN_BITS-1 and cap_en_i: go to FINAL.
    - Plane IN_BITS-1 is the sign plane and is subtracted instead of added (two's-complement input).
  - FINAL (one cycle): if zp_en, buf[g] <= sat(buf[g] - zero_point); go to READY.
  - READY --drain_i--> DRAIN; idx <= drain_idx_i.
  - DRAIN: out_valid_o = 1, out_data_o = buf[idx], out_last_o = (idx == N_GROUPS-1).
    - On out_valid_o && out_ready_i: if out_last_o go to READY, else idx++.
    - Data and last are held stable while stalled.
- Latency: start_i to CAPTURE is 1 cycle. Last capture to ready_o is 1 cycle (raw) or 2 cycles (MAC). drain_i to first out_valid_o is 1 cycle.
- Arithmetic: all MAC operations use an ACC_W+IN_BITS+1-bit intermediate, saturated to signed ACC_W (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)). Any clamp sets ovf_o.
- Boundaries:
  - cap_en_i outside CAPTURE: ignored, sets err_o.
  - drain_i outside READY: ignored, sets err_o.
  - Simultaneous start_i and cap_en_i: start_i wins; the capture is dropped.
  - Simultaneous drain_i and start_i in READY: start_i wins.
  - Drain may be repeated from READY any number of times; the buffer is preserved.
  - Reset mid-drain: out_valid_o drops asynchronously.

Decomposition:
- Package output_buffer_pkg:
  - FSM state enum ob_state_e.
  - mode constants OB_MODE_RAW/OB_MODE_MAC.
  - saturation function sat_acc.
- One sub-module ob_group_acc (one per group via generate): holds buf[g] and performs the raw/shift-accumulate/zero-point update and saturation. Inputs are plane, op and operands; outputs are value and ovf.
- Top level holds the FSM, plane counter, drain index and output mux.

Test Plan:
- Raw: start mode=0; cap with group 5 = 0xDEADBEEF; drain idx 0 -> 32 beats, beat 5 = 0xDEADBEEF, last only on beat 31, then ready_o = 1.
- MAC: IN_BITS=8, all groups = 1 on planes 0..6 and 0 on plane 7 -> every word = 127. Repeat with plane 7 = 1 -> every word = -1.
- Zero point: MAC with result 100 per group, zp_en=1, zero_point=30 -> all words 70. Same with zp_en=0 -> 100.
- Saturation: groups 0x7FFFFFFF on planes 0..6 -> word 0x7FFFFFFF, ovf_o = 1. Next start_i clears ovf_o.
- Backpressure/random start: drain_idx_i=29, out_ready_i toggling 1010... -> beats 29, 30, 31 each held stable while stalled; last on 31; 3 accepted beats total.
- Protocol/abort: cap_en_i in IDLE -> err_o = 1, buffer unchanged. start_i mid-DRAIN -> out_valid_o = 0 next cycle, busy_o = 1, buffer all 0.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// Shared types for the PIM output buffer: FSM states, per-group ops, mode codes
// and the signed saturation helper used by every group accumulator.
package output_buffer_pkg;

    typedef enum logic [2:0] {
        OB_IDLE,
        OB_CAPTURE,
        OB_FINAL,
        OB_READY,
        OB_DRAIN
    } ob_state_e;

    typedef enum logic [2:0] {
        OB_OP_NONE,
        OB_OP_CLEAR,
        OB_OP_RAW,
        OB_OP_MAC,
        OB_OP_ZP
    } ob_op_e;

    localparam logic OB_MODE_RAW = 1'b0;
    localparam logic OB_MODE_MAC = 1'b1;

    // Intermediates are sign-extended to this width before clamping.
    localparam int OB_SAT_W = 64;

    typedef struct packed {
        logic                ovf;
        logic [OB_SAT_W-1:0] val;
    } ob_sat_t;

    function automatic ob_sat_t sat_acc(input logic signed [OB_SAT_W-1:0] x,
                                        input int unsigned acc_w);
        logic signed [OB_SAT_W-1:0] max_v;
        logic signed [OB_SAT_W-1:0] min_v;
        ob_sat_t r;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (acc_w - 1));
        r.ovf = 1'b0;
        r.val = x;
        if (x > max_v) begin
            r.ovf = 1'b1;
            r.val = max_v;
        end else if (x < min_v) begin
            r.ovf = 1'b1;
            r.val = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/output_buffer_stream_acc.sv
// One buffer entry: raw capture, bit-serial shift-accumulate and zero-point
// subtraction with signed saturation; updates one cycle after op_i, ovf_o is combinational.
module ob_group_acc
    import output_buffer_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int GROUP_W = 32,
    parameter int IN_BITS = 8,
    parameter int PLANE_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  ob_op_e             op_i,
    input  logic [PLANE_W-1:0] plane_i,
    input  logic [GROUP_W-1:0] group_i,
    input  logic [ACC_W-1:0]   zero_point_i,
    output logic [ACC_W-1:0]   value_o,
    output logic               ovf_o
);

    localparam int IW = ACC_W + IN_BITS + 1;
    localparam logic [PLANE_W-1:0] SIGN_PLANE = PLANE_W'(IN_BITS - 1);

    logic [ACC_W-1:0]  value_q;
    logic [ACC_W-1:0]  value_d;
    logic signed [IW-1:0] acc_x;
    logic signed [IW-1:0] term_x;
    logic signed [IW-1:0] zp_x;
    logic signed [IW-1:0] sum_x;
    ob_sat_t sat_r;

    always_comb begin
        acc_x  = {{(IW-ACC_W){value_q[ACC_W-1]}}, value_q};
        term_x = {{(IW-GROUP_W){group_i[GROUP_W-1]}}, group_i} <<< plane_i;
        zp_x   = {{(IW-ACC_W){zero_point_i[ACC_W-1]}}, zero_point_i};
        sum_x  = acc_x;
        if (op_i == OB_OP_MAC) begin
            // The top plane carries the two's-complement sign weight.
            sum_x = (plane_i == SIGN_PLANE) ? acc_x - term_x : acc_x + term_x;
        end else if (op_i == OB_OP_ZP) begin
            sum_x = acc_x - zp_x;
        end
        sat_r = sat_acc({{(OB_SAT_W-IW){sum_x[IW-1]}}, sum_x}, ACC_W);

        value_d = value_q;
        ovf_o   = 1'b0;
        case (op_i)
            OB_OP_CLEAR: value_d = '0;
            OB_OP_RAW:   value_d = ACC_W'(group_i);
            OB_OP_MAC, OB_OP_ZP: begin
                value_d = sat_r.val[ACC_W-1:0];
                ovf_o   = sat_r.ovf;
            end
            default: value_d = value_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/output_buffer_stream.sv
// PIM result buffer: captures raw or bit-serial MAC results per group and drains them
// as a valid/ready stream; ready_o 1 (raw) / 2 (MAC) cycles after last capture, data held while stalled.
module output_buffer_stream
    import output_buffer_pkg::*;
#(
    parameter int N_GROUPS = 32,
    parameter int GROUP_W  = 32,
    parameter int ACC_W    = 32,
    parameter int IN_BITS  = 8,
    parameter int IDX_W    = $clog2(N_GROUPS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_GROUPS*GROUP_W-1:0] output_i,
    input  logic                        mode_i,
    input  logic                        start_i,
    input  logic                        cap_en_i,
    input  logic                        zp_en_i,
    input  logic [ACC_W-1:0]            zero_point_i,
    input  logic                        drain_i,
    input  logic [IDX_W-1:0]            drain_idx_i,
    output logic [ACC_W-1:0]            out_data_o,
    output logic                        out_valid_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i,
    output logic                        busy_o,
    output logic                        ready_o,
    output logic                        ovf_o,
    output logic                        err_o
);

    localparam int PLANE_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_GROUPS - 1);
    localparam logic [PLANE_W-1:0] SIGN_PLANE = PLANE_W'(IN_BITS - 1);

    ob_state_e          state_q;
    ob_state_e          state_d;
    logic               mode_q;
    logic               zp_en_q;
    logic [ACC_W-1:0]   zp_q;
    logic [PLANE_W-1:0] plane_q;
    logic [IDX_W-1:0]   idx_q;
    logic               ovf_q;
    logic               err_q;
    logic               valid_q;
    logic               busy_q;
    logic               ready_q;

    ob_op_e             grp_op;
    logic [ACC_W-1:0]   grp_val [N_GROUPS];
    logic [N_GROUPS-1:0] grp_ovf;
    logic               beat_fire;
    logic               cap_err;
    logic               drain_err;

    assign beat_fire = valid_q && out_ready_i;
    assign cap_err   = cap_en_i && (state_q != OB_CAPTURE);
    assign drain_err = drain_i && (state_q != OB_READY);

    always_comb begin
        state_d = state_q;
        grp_op  = OB_OP_NONE;
        if (start_i) begin
            state_d = OB_CAPTURE;
            grp_op  = OB_OP_CLEAR;
        end else begin
            case (state_q)
                OB_IDLE: state_d = OB_IDLE;
                OB_CAPTURE: begin
                    if (cap_en_i) begin
                        if (mode_q == OB_MODE_RAW) begin
                            grp_op  = OB_OP_RAW;
                            state_d = OB_READY;
                        end else begin
                            grp_op = OB_OP_MAC;
                            if (plane_q == SIGN_PLANE) state_d = OB_FINAL;
                        end
                    end
                end
                OB_FINAL: begin
                    if (zp_en_q) grp_op = OB_OP_ZP;
                    state_d = OB_READY;
                end
                OB_READY: if (drain_i) state_d = OB_DRAIN;
                OB_DRAIN: if (beat_fire && idx_q == LAST_IDX) state_d = OB_READY;
                default:  state_d = OB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OB_IDLE;
            mode_q  <= OB_MODE_RAW;
            zp_en_q <= 1'b0;
            zp_q    <= '0;
            plane_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= !(state_d inside {OB_IDLE, OB_READY});
            ready_q <= (state_d == OB_READY);
            valid_q <= (state_d == OB_DRAIN);
            if (start_i) begin
                mode_q  <= mode_i;
                zp_en_q <= zp_en_i;
                zp_q    <= zero_point_i;
                plane_q <= '0;
                ovf_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                if (|grp_ovf) ovf_q <= 1'b1;
                if (cap_err || drain_err) err_q <= 1'b1;
                if (state_q == OB_CAPTURE && cap_en_i && mode_q == OB_MODE_MAC) begin
                    plane_q <= (plane_q == SIGN_PLANE) ? '0 : plane_q + PLANE_W'(1);
                end
                if (state_q == OB_READY && drain_i) begin
                    idx_q <= drain_idx_i;
                end else if (state_q == OB_DRAIN && beat_fire && idx_q != LAST_IDX) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
        ob_group_acc #(
            .ACC_W   (ACC_W),
            .GROUP_W (GROUP_W),
            .IN_BITS (IN_BITS),
            .PLANE_W (PLANE_W)
        ) u_acc (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .op_i         (grp_op),
            .plane_i      (plane_q),
            .group_i      (output_i[N_GROUPS*GROUP_W-1-GROUP_W*g -: GROUP_W]),
            .zero_point_i (zp_q),
            .value_o      (grp_val[g]),
            .ovf_o        (grp_ovf[g])
        );
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = valid_q ? grp_val[idx_q] : '0;
    assign out_last_o  = valid_q && (idx_q == LAST_IDX);
    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign ovf_o       = ovf_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_output_buffer_stream.sv
// Randomised bench for output_buffer_stream against an arithmetic model of the
// buffer contents (signed integer sums per group, clamped to the 32-bit range).
module tb_output_buffer_stream;

    localparam int N  = 32;
    localparam int GW = 32;
    localparam int AW = 32;
    localparam int IB = 8;
    localparam int XW = 5;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N*GW-1:0] output_i = '0;
    logic            mode_i = 1'b0;
    logic            start_i = 1'b0;
    logic            cap_en_i = 1'b0;
    logic            zp_en_i = 1'b0;
    logic [AW-1:0]   zero_point_i = '0;
    logic            drain_i = 1'b0;
    logic [XW-1:0]   drain_idx_i = '0;
    logic [AW-1:0]   out_data_o;
    logic            out_valid_o;
    logic            out_last_o;
    logic            out_ready_i = 1'b0;
    logic            busy_o;
    logic            ready_o;
    logic            ovf_o;
    logic            err_o;

    int checks = 0;
    int failures = 0;

    longint        m_buf [N];
    bit            m_ovf;
    bit            m_zpen;
    longint        m_zp;
    logic [GW-1:0] words [N];
    logic [GW-1:0] planes [IB][N];

    output_buffer_stream #(
        .N_GROUPS(N), .GROUP_W(GW), .ACC_W(AW), .IN_BITS(IB), .IDX_W(XW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .output_i     (output_i),
        .mode_i       (mode_i),
        .start_i      (start_i),
        .cap_en_i     (cap_en_i),
        .zp_en_i      (zp_en_i),
        .zero_point_i (zero_point_i),
        .drain_i      (drain_i),
        .drain_idx_i  (drain_idx_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_last_o   (out_last_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .ready_o      (ready_o),
        .ovf_o        (ovf_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    function automatic longint clamp(input longint v);
        if (v > MAXV) begin
            m_ovf = 1'b1;
            return MAXV;
        end
        if (v < MINV) begin
            m_ovf = 1'b1;
            return MINV;
        end
        return v;
    endfunction

    function automatic logic [GW-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return GW'($urandom);
            1:       return GW'(int'($urandom_range(0, 16)) - 8);
            2:       return 32'h7FFF_FFFF;
            default: return GW'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic pack_words();
        for (int g = 0; g < N; g++) output_i[N*GW-1-GW*g -: GW] = words[g];
    endtask

    task automatic do_start(input logic mode, input logic zpen, input logic [AW-1:0] zp,
                            input logic with_cap, input logic with_drain);
        for (int g = 0; g < N; g++) words[g] = rand_word();
        pack_words();
        start_i = 1'b1; mode_i = mode; zp_en_i = zpen; zero_point_i = zp;
        cap_en_i = with_cap; drain_i = with_drain; drain_idx_i = '0;
        tick();
        start_i = 1'b0; cap_en_i = 1'b0; drain_i = 1'b0;
        for (int g = 0; g < N; g++) m_buf[g] = 0;
        m_ovf = 1'b0; m_zpen = zpen; m_zp = longint'(signed'(zp));
        check("start_busy", busy_o, 1);
        check("start_ready", ready_o, 0);
        check("start_vld", out_valid_o, 0);
        check("start_ovf", ovf_o, 0);
        check("start_err", err_o, 0);
    endtask

    task automatic drive_cap();
        pack_words();
        cap_en_i = 1'b1;
        tick();
        cap_en_i = 1'b0;
    endtask

    task automatic raw_op();
        do_start(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), 1'b0, 1'b0);
        for (int g = 0; g < N; g++) words[g] = rand_word();
        words[5] = 32'hDEAD_BEEF;
        drive_cap();
        for (int g = 0; g < N; g++) m_buf[g] = longint'({32'b0, words[g]});
        check("raw_ready", ready_o, 1);
        check("raw_busy", busy_o, 0);
        check("raw_ovf", ovf_o, 0);
    endtask

    task automatic mac_caps();
        for (int p = 0; p < IB; p++) begin
            for (int g = 0; g < N; g++) words[g] = planes[p][g];
            drive_cap();
            for (int g = 0; g < N; g++) begin
                longint term;
                term = longint'(signed'(words[g])) * (64'sd1 <<< p);
                m_buf[g] = clamp((p == IB - 1) ? m_buf[g] - term : m_buf[g] + term);
            end
            if (p < IB - 1) check("mac_busy", busy_o, 1);
        end
        check("mac_final_ready", ready_o, 0);
        tick();
        if (m_zpen) begin
            for (int g = 0; g < N; g++) m_buf[g] = clamp(m_buf[g] - m_zp);
        end
        check("mac_ready", ready_o, 1);
        check("mac_ovf", ovf_o, m_ovf);
        check("mac_err", err_o, 0);
    endtask

    task automatic mac_op(input logic zpen, input logic [AW-1:0] zp);
        do_start(1'b1, zpen, zp, 1'b0, 1'b0);
        mac_caps();
    endtask

    // pat 0: always ready, 1: ready on odd cycles only, 2: random ready
    task automatic drain(input int first, input int pat);
        int cur;
        int cyc;
        int accepted;
        logic rdy;
        drain_i = 1'b1; drain_idx_i = XW'(first);
        tick();
        drain_i = 1'b0;
        cur = first; cyc = 0; accepted = 0;
        while (cur < N && cyc < 4 * N + 8) begin
            check("drain_vld", out_valid_o, 1);
            check("drain_dat", out_data_o, 64'(m_buf[cur][31:0]));
            check("drain_last", out_last_o, (cur == N - 1));
            check("drain_busy", busy_o, 1);
            rdy = (pat == 0) ? 1'b1 : (pat == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            out_ready_i = rdy;
            tick();
            out_ready_i = 1'b0;
            if (rdy) begin
                cur++;
                accepted++;
            end
            cyc++;
        end
        check("drain_beats", accepted, N - first);
        check("drain_end_vld", out_valid_o, 0);
        check("drain_end_ready", ready_o, 1);
    endtask

    task automatic set_planes_bits(input logic [IB-1:0] bits, input logic [GW-1:0] val);
        for (int p = 0; p < IB; p++)
            for (int g = 0; g < N; g++) planes[p][g] = bits[p] ? val : '0;
    endtask

    initial begin
        tick();
        check("rst_vld", out_valid_o, 0);
        check("rst_dat", out_data_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_err", err_o, 0);
        rst_ni = 1'b1;
        tick();

        for (int g = 0; g < N; g++) words[g] = rand_word();
        drive_cap();
        check("idle_cap_err", err_o, 1);
        check("idle_cap_busy", busy_o, 0);
        drain_i = 1'b1;
        tick();
        drain_i = 1'b0;
        check("idle_drain_vld", out_valid_o, 0);

        raw_op();
        drain(0, 0);
        for (int g = 0; g < N; g++) words[g] = rand_word();
        drive_cap();
        check("ready_cap_err", err_o, 1);
        check("ready_cap_ready", ready_o, 1);
        drain(7, 2);
        drain(0, 2);

        set_planes_bits(8'b0111_1111, 32'd1);
        mac_op(1'b0, '0);
        check("mac127_g0", dut.out_data_o, 0);
        drain(0, 0);
        set_planes_bits(8'b1111_1111, 32'd1);
        mac_op(1'b0, '0);
        drain(0, 2);

        set_planes_bits(8'b0110_0100, 32'd1);
        mac_op(1'b1, 32'd30);
        drain(0, 0);
        mac_op(1'b0, 32'd30);
        drain(16, 2);

        set_planes_bits(8'b0111_1111, 32'h7FFF_FFFF);
        mac_op(1'b0, '0);
        check("sat_ovf", ovf_o, 1);
        drain(0, 2);

        raw_op();
        drain(29, 1);

        do_start(1'b0, 1'b0, '0, 1'b0, 1'b1);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int p = 0; p < IB; p++)
                    for (int g = 0; g < N; g++) planes[p][g] = rand_word();
                do_start(1'b1, 1'($urandom_range(0, 1)), AW'($urandom),
                         1'($urandom_range(0, 1)), 1'b0);
                mac_caps();
            end else begin
                raw_op();
            end
            drain($urandom_range(0, N - 1), 2);
        end

        raw_op();
        drain_i = 1'b1; drain_idx_i = '0;
        tick();
        drain_i = 1'b0; out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        check("abort_pre_vld", out_valid_o, 1);
        do_start(1'b1, 1'b0, '0, 1'b0, 1'b0);
        set_planes_bits(8'b0000_0000, 32'd0);
        mac_caps();
        drain(0, 0);

        raw_op();
        drain_i = 1'b1; drain_idx_i = XW'(3);
        tick();
        drain_i = 1'b0;
        check("rstmid_vld_before", out_valid_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rstmid_vld", out_valid_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_ready", ready_o, 0);
        check("rstmid_dat", out_data_o, 0);
        rst_ni = 1'b1;
        tick();
        check("rstmid_idle_vld", out_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
